// File: rtl/tone_synth.sv
// tone_synth: note-code driven sine tone generator with attack/sustain/release envelope.
// One signed PCM sample per advance strobe through a registered lookup -> multiply pipeline.
module tone_synth #(
   parameter int                 SAMPLE_W     = 16,
   parameter int                 PHASE_W      = 24,
   parameter logic [PHASE_W-1:0] TUNE1        = 24'h040000,
   parameter logic [PHASE_W-1:0] TUNE2        = 24'h050000,
   parameter logic [PHASE_W-1:0] TUNE3        = 24'h060000,
   parameter logic [PHASE_W-1:0] TUNE4        = 24'h080000,
   parameter logic [7:0]         ATTACK_STEP  = 8'd64,
   parameter logic [7:0]         RELEASE_STEP = 8'd32,
   parameter int                 HOLD_SAMPLES = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       note_valid,
   input  logic [2:0]                 note,
   output logic                       note_ready,
   input  logic                       advance,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       sample_valid,
   output logic [2:0]                 active_note,
   output logic                       busy
);
   localparam int         LUT_AW    = 8;
   localparam int         PROD_W    = SAMPLE_W + 9;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_SAMPLES - 1);

   // quarter-wave magnitudes round(32767*sin(2*pi*(i+0.5)/256)); the half-step offset keeps the mirrored quadrants symmetric
   localparam logic [SAMPLE_W-2:0] SINE_Q [0:63] = '{
      15'd402,   15'd1206,  15'd2009,  15'd2811,  15'd3612,  15'd4410,  15'd5205,  15'd5998,
      15'd6786,  15'd7571,  15'd8351,  15'd9126,  15'd9896,  15'd10659, 15'd11417, 15'd12167,
      15'd12910, 15'd13645, 15'd14372, 15'd15090, 15'd15800, 15'd16499, 15'd17189, 15'd17869,
      15'd18537, 15'd19195, 15'd19841, 15'd20475, 15'd21096, 15'd21705, 15'd22301, 15'd22884,
      15'd23452, 15'd24007, 15'd24547, 15'd25072, 15'd25582, 15'd26077, 15'd26556, 15'd27019,
      15'd27466, 15'd27896, 15'd28310, 15'd28706, 15'd29085, 15'd29447, 15'd29791, 15'd30117,
      15'd30424, 15'd30714, 15'd30985, 15'd31237, 15'd31470, 15'd31685, 15'd31880, 15'd32057,
      15'd32213, 15'd32351, 15'd32469, 15'd32567, 15'd32646, 15'd32705, 15'd32745, 15'd32765
   };

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ATTACK  = 2'd1,
      S_SUSTAIN = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                      r_state, w_state_n;
   logic [PHASE_W-1:0]          r_phase, w_phase_n, r_tune, w_tune_n;
   logic [7:0]                  r_env, w_env_n, r_hold, w_hold_n, r_env1;
   logic [8:0]                  w_env_sum;
   logic [2:0]                  r_active, w_active_n;
   logic                        r_ready, r_busy, w_accept, w_note_ok;
   logic                        r_adv_d, r_lut_v, r_sval;
   logic [LUT_AW-3:0]           w_idx;
   logic signed [SAMPLE_W-1:0]  w_sine, r_sine, r_sample;
   logic signed [8:0]           w_env_s;
   logic signed [PROD_W-1:0]    w_prod;

   function automatic logic [PHASE_W-1:0] tune_for(input logic [2:0] n);
      case (n)
         3'd1:    tune_for = TUNE1;
         3'd2:    tune_for = TUNE2;
         3'd3:    tune_for = TUNE3;
         3'd4:    tune_for = TUNE4;
         default: tune_for = {PHASE_W{1'b0}};
      endcase
   endfunction

   assign w_accept  = note_valid && r_ready;
   assign w_note_ok = (note >= 3'd1) && (note <= 3'd4);
   assign w_env_sum = {1'b0, r_env} + {1'b0, ATTACK_STEP};

   // next-state: the advance steps the pre-accept state, then a same-cycle accept overrides state and tune
   always_comb begin
      w_state_n  = r_state;
      w_phase_n  = r_phase;
      w_tune_n   = r_tune;
      w_env_n    = r_env;
      w_hold_n   = r_hold;
      w_active_n = r_active;
      if (advance) begin
         if (r_state != S_IDLE) begin
            w_phase_n = r_phase + r_tune;
         end else begin
            w_phase_n = r_phase;
         end
         case (r_state)
            S_ATTACK: begin
               if (w_env_sum >= 9'd255) begin
                  w_env_n   = 8'd255;
                  w_state_n = S_SUSTAIN;
                  w_hold_n  = 8'd0;
               end else begin
                  w_env_n   = w_env_sum[7:0];
               end
            end
            S_SUSTAIN: begin
               if (r_hold == HOLD_LAST) begin
                  w_state_n = S_RELEASE;
               end else begin
                  w_hold_n  = r_hold + 8'd1;
               end
            end
            S_RELEASE: begin
               if (r_env > RELEASE_STEP) begin
                  w_env_n    = r_env - RELEASE_STEP;
               end else begin
                  w_env_n    = 8'd0;
                  w_state_n  = S_IDLE;
                  w_active_n = 3'd0;
               end
            end
            default: w_state_n = r_state;
         endcase
      end else begin
         w_phase_n = r_phase;
      end
      if (w_accept && w_note_ok) begin
         w_state_n  = S_ATTACK;
         w_active_n = note;
         w_tune_n   = tune_for(note);
      end else begin
         w_tune_n   = r_tune;
      end
   end

   // quadrant unfolding of the quarter-wave table
   always_comb begin
      w_idx  = r_phase[PHASE_W-3 -: LUT_AW-2];
      w_sine = {SAMPLE_W{1'b0}};
      case (r_phase[PHASE_W-1 -: 2])
         2'd0:    w_sine =  $signed({1'b0, SINE_Q[w_idx]});
         2'd1:    w_sine =  $signed({1'b0, SINE_Q[~w_idx]});
         2'd2:    w_sine = -$signed({1'b0, SINE_Q[w_idx]});
         default: w_sine = -$signed({1'b0, SINE_Q[~w_idx]});
      endcase
   end

   assign w_env_s = $signed({1'b0, r_env1});
   assign w_prod  = PROD_W'(r_sine) * PROD_W'(w_env_s);

   // FSM, oscillator, envelope and registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_phase  <= {PHASE_W{1'b0}};
         r_tune   <= {PHASE_W{1'b0}};
         r_env    <= 8'd0;
         r_hold   <= 8'd0;
         r_active <= 3'd0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_phase  <= w_phase_n;
         r_tune   <= w_tune_n;
         r_env    <= w_env_n;
         r_hold   <= w_hold_n;
         r_active <= w_active_n;
         r_ready  <= (w_state_n == S_IDLE) || (w_state_n == S_RELEASE);
         r_busy   <= (w_state_n != S_IDLE);
      end
   end

   // two-stage sample pipeline: table read, then envelope multiply
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_adv_d  <= 1'b0;
         r_lut_v  <= 1'b0;
         r_sval   <= 1'b0;
         r_sine   <= {SAMPLE_W{1'b0}};
         r_env1   <= 8'd0;
         r_sample <= {SAMPLE_W{1'b0}};
      end else begin
         r_adv_d <= advance;
         r_lut_v <= r_adv_d;
         r_sval  <= r_lut_v;
         if (r_adv_d) begin
            r_sine <= w_sine;
            r_env1 <= r_env;
         end else begin
            r_sine <= r_sine;
            r_env1 <= r_env1;
         end
         if (r_lut_v) begin
            r_sample <= SAMPLE_W'(w_prod >>> 4'd8);
         end else begin
            r_sample <= r_sample;
         end
      end
   end

   assign note_ready   = r_ready;
   assign busy         = r_busy;
   assign active_note  = r_active;
   assign sample       = r_sample;
   assign sample_valid = r_sval;
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed stimulus with a sample scoreboard; expected samples are
// hand-computed from round(32767*sin(2*pi*(i+0.5)/256)) times the envelope, floored by >>>8.
module tb_tone_synth;
   logic              clk = 1'b0;
   logic              reset;
   logic              note_valid;
   logic [2:0]        note;
   logic              note_ready;
   logic              advance;
   logic signed [15:0] sample;
   logic              sample_valid;
   logic [2:0]        active_note;
   logic              busy;

   typedef struct {
      logic signed [15:0] val;
      int                 due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   n_samp = 0;
   int   total  = 0;
   int   bad    = 0;

   tone_synth dut (
      .clk          (clk),
      .reset        (reset),
      .note_valid   (note_valid),
      .note         (note),
      .note_ready   (note_ready),
      .advance      (advance),
      .sample       (sample),
      .sample_valid (sample_valid),
      .active_note  (active_note),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // monitor: every sample_valid pulse must match the oldest expected sample and its due cycle
   always @(negedge clk) begin
      if (sample_valid === 1'b1) begin
         n_samp++;
         if (sb_q.size() == 0) begin
            check($sformatf("unexpected sample_valid #%0d", n_samp), 32'sd1, 32'sd0);
         end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("sample #%0d value", n_samp), sample, mon_e.val);
            check($sformatf("sample #%0d latency", n_samp), cyc, mon_e.due);
         end
      end
   end

   task automatic adv(input logic signed [15:0] e);
      @(negedge clk);
      advance = 1'b1;
      sb_q.push_back('{val: e, due: cyc + 3});
      @(negedge clk);
      advance = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_note(input logic [2:0] n);
      @(negedge clk);
      note_valid = 1'b1;
      note       = n;
      @(negedge clk);
      note_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset      = 1'b0;
      note_valid = 1'b0;
      note       = 3'd0;
      advance    = 1'b0;
      repeat (2) @(negedge clk);
      check("reset sample", sample, 32'sd0);
      check("reset sample_valid", sample_valid, 32'sd0);
      check("reset busy", busy, 32'sd0);
      check("reset active_note", active_note, 32'sd0);
      reset = 1'b1;
      @(negedge clk);
      check("note_ready after reset", note_ready, 32'sd1);

      // invalid codes are consumed without starting a tone
      send_note(3'd0);
      check("note0 busy", busy, 32'sd0);
      send_note(3'd6);
      check("note6 busy", busy, 32'sd0);
      check("note6 active_note", active_note, 32'sd0);
      adv(16'sd0);

      // note 1: attack, sustain, release
      send_note(3'd1);
      check("note1 active_note", active_note, 32'sd1);
      check("note1 busy", busy, 32'sd1);
      check("attack note_ready", note_ready, 32'sd0);
      adv(16'sd903);   adv(16'sd3393);  adv(16'sd7422);  adv(16'sd12859);
      adv(16'sd15738); adv(16'sd18464); adv(16'sd21013); adv(16'sd23360);
      adv(16'sd25482); adv(16'sd27358); adv(16'sd28971);
      check("sustain note_ready", note_ready, 32'sd0);
      adv(16'sd30305);
      check("release note_ready", note_ready, 32'sd1);
      adv(16'sd27413); adv(16'sd24033); adv(16'sd20276); adv(16'sd16254);
      adv(16'sd12085); adv(16'sd7889);  adv(16'sd3782);
      check("late release busy", busy, 32'sd1);
      adv(16'sd0);
      check("end active_note", active_note, 32'sd0);
      check("end busy", busy, 32'sd0);
      check("end note_ready", note_ready, 32'sd1);

      // note 4 accepted in the same cycle as an advance: that sample is still silent
      @(negedge clk);
      note_valid = 1'b1;
      note       = 3'd4;
      advance    = 1'b1;
      sb_q.push_back('{val: 16'sd0, due: cyc + 3});
      @(negedge clk);
      note_valid = 1'b0;
      advance    = 1'b0;
      repeat (2) @(negedge clk);
      check("note4 active_note", active_note, 32'sd4);
      adv(16'sd6754); adv(16'sd11442); adv(16'sd13401); adv(16'sd12119);

      // note 2 requested during sustain is held until release
      note_valid = 1'b1;
      note       = 3'd2;
      adv(16'sd5974);
      check("held note_ready", note_ready, 32'sd0);
      adv(-16'sd401);   adv(-16'sd6760);  adv(-16'sd12860);
      adv(-16'sd18465); adv(-16'sd23361); adv(-16'sd27359);
      check("held active_note", active_note, 32'sd4);
      adv(-16'sd30306);
      note_valid = 1'b0;
      check("retrigger active_note", active_note, 32'sd2);
      check("retrigger busy", busy, 32'sd1);
      check("retrigger note_ready", note_ready, 32'sd0);
      adv(-16'sd31562); adv(-16'sd32343);

      // asynchronous reset with a sample in flight
      @(negedge clk);
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midreset sample", sample, 32'sd0);
      check("midreset busy", busy, 32'sd0);
      check("midreset active_note", active_note, 32'sd0);
      check("midreset sample_valid", sample_valid, 32'sd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post-reset note_ready", note_ready, 32'sd1);
      check("post-reset busy", busy, 32'sd0);
      send_note(3'd1);
      adv(16'sd903);
      repeat (4) @(negedge clk);
      check("scoreboard drained", sb_q.size(), 32'sd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
